// File: rtl/dma_mem_pkg.sv
// rtl/dma_mem_pkg.sv - shared defaults, widths and helpers for the DMA memory server
package dma_mem_pkg;

  localparam int DW_DEF     = 8;
  localparam int AW_DEF     = 16;
  localparam int DEPTH_DEF  = 1024;
  localparam int RD_LAT_DEF = 2;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 16;
  localparam int STALL_W    = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/dma_rd_pipe.sv
// rtl/dma_rd_pipe.sv - LAT-deep valid/data shift chain for read returns
module dma_rd_pipe #(
  parameter int DW  = 8,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  // Data only moves with its valid bit, so the last stage holds the most
  // recent returned word between pulses.
  for (genvar g = 0; g < LAT; g++) begin : g_stage
    logic          v_q;
    logic [DW-1:0] d_q;
    logic          prev_v;
    logic [DW-1:0] prev_d;

    if (g == 0) begin : g_head
      assign prev_v = in_valid;
      assign prev_d = in_data;
    end else begin : g_tail
      assign prev_v = g_stage[g-1].v_q;
      assign prev_d = g_stage[g-1].d_q;
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= prev_v;
        if (prev_v) d_q <= prev_d;
      end
    end
  end

  assign out_valid = g_stage[LAT-1].v_q;
  assign out_data  = g_stage[LAT-1].d_q;

endmodule

// File: rtl/dma_mem_serv.sv
// rtl/dma_mem_serv.sv - single-port memory slave with pipelined reads, throttling and error flags
module dma_mem_serv
  import dma_mem_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               bus_clk,
  input  logic               rstn,
  input  logic               bus_rd,
  input  logic               bus_wr,
  input  logic [AW-1:0]      bus_addr,
  input  logic [DW-1:0]      bus_wdata,
  output logic               bus_ready,
  output logic               bus_rdata_ready,
  output logic [DW-1:0]      bus_rdata,
  input  logic               cfg_stall_en,
  input  logic [STALL_W-1:0] cfg_stall_pat,
  input  logic               err_clr,
  output logic               err_addr,
  output logic               err_proto,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   rd_cnt
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0]      mem [DEPTH];
  logic               in_range;
  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic [DW-1:0]      rd_word;
  logic [STALL_W-1:0] stall_rot;
  logic [STALL_W-1:0] rot_next;
  logic               stall_en_q;

  assign in_range = ({1'b0, bus_addr} < DEPTH_W);
  assign accept   = rstn && bus_ready && (bus_rd || bus_wr);
  assign wr_acc   = accept && bus_wr;
  // A simultaneous read and write keeps only the write.
  assign rd_acc   = accept && bus_rd && !bus_wr;
  assign rd_word  = in_range ? mem[bus_addr[IW-1:0]] : '1;

  always_ff @(posedge bus_clk) begin
    if (wr_acc && in_range) mem[bus_addr[IW-1:0]] <= bus_wdata;
  end

  always_comb begin
    rot_next = stall_rot;
    if (cfg_stall_en && !stall_en_q) rot_next = cfg_stall_pat;
    else if (cfg_stall_en)           rot_next = {stall_rot[0], stall_rot[STALL_W-1:1]};
  end

  always_ff @(posedge bus_clk) begin
    if (!rstn) begin
      bus_ready  <= 1'b0;
      stall_rot  <= '1;
      stall_en_q <= 1'b0;
      err_addr   <= 1'b0;
      err_proto  <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
    end else begin
      stall_en_q <= cfg_stall_en;
      stall_rot  <= rot_next;
      bus_ready  <= cfg_stall_en ? rot_next[0] : 1'b1;

      // Setting takes priority over a same-cycle clear.
      if (accept && !in_range)              err_addr <= 1'b1;
      else if (err_clr)                     err_addr <= 1'b0;
      if (accept && bus_rd && bus_wr)       err_proto <= 1'b1;
      else if (err_clr)                     err_proto <= 1'b0;

      if (wr_acc) wr_cnt <= sat_inc(wr_cnt);
      if (rd_acc) rd_cnt <= sat_inc(rd_cnt);
    end
  end

  dma_rd_pipe #(
    .DW  (DW),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (bus_clk),
    .rstn      (rstn),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (bus_rdata_ready),
    .out_data  (bus_rdata)
  );

endmodule

// File: tb/tb_dma_mem_serv.sv
// tb/tb_dma_mem_serv.sv - self-checking bench for dma_mem_serv (8-bit/lat 2 and 32-bit/lat 4 instances)
module tb_dma_mem_serv;

  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic        bus_clk = 1'b0;
  logic        rstn, bus_rd, bus_wr, cfg_stall_en, err_clr;
  logic [15:0] bus_addr;
  logic [31:0] wdata32;
  logic [7:0]  cfg_stall_pat;

  logic        a_ready, a_rv, a_err_addr, a_err_proto;
  logic [7:0]  a_rdata;
  logic [15:0] a_wr_cnt, a_rd_cnt;
  logic        b_ready, b_rv, b_err_addr, b_err_proto;
  logic [31:0] b_rdata;
  logic [15:0] b_wr_cnt, b_rd_cnt;

  always #5 bus_clk = ~bus_clk;

  dma_mem_serv #(.DW(8), .AW(AW), .DEPTH(DEPTH), .RD_LAT(2)) dut_a (
    .bus_clk(bus_clk), .rstn(rstn), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(wdata32[7:0]), .bus_ready(a_ready),
    .bus_rdata_ready(a_rv), .bus_rdata(a_rdata), .cfg_stall_en(cfg_stall_en),
    .cfg_stall_pat(cfg_stall_pat), .err_clr(err_clr), .err_addr(a_err_addr),
    .err_proto(a_err_proto), .wr_cnt(a_wr_cnt), .rd_cnt(a_rd_cnt));

  dma_mem_serv #(.DW(32), .AW(AW), .DEPTH(DEPTH), .RD_LAT(4)) dut_b (
    .bus_clk(bus_clk), .rstn(rstn), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(wdata32), .bus_ready(b_ready),
    .bus_rdata_ready(b_rv), .bus_rdata(b_rdata), .cfg_stall_en(cfg_stall_en),
    .cfg_stall_pat(cfg_stall_pat), .err_clr(err_clr), .err_addr(b_err_addr),
    .err_proto(b_err_proto), .wr_cnt(b_wr_cnt), .rd_cnt(b_rd_cnt));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit sb_on = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rd, wr, clr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [15:0] wc, rc;
    logic        ea, ep;
  } vec_t;

  exp_t        qa[$], qb[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_a, last_b, rd_exp;
  logic        in_rng;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic clr,
                       input logic [15:0] addr, input logic [31:0] wd);
    bus_rd = rd; bus_wr = wr; err_clr = clr; bus_addr = addr; wdata32 = wd;
    @(posedge bus_clk); #1;
  endtask

  task automatic check_reset_vals();
    check("rst_a_ready", a_ready, 0);  check("rst_b_ready", b_ready, 0);
    check("rst_a_rv", a_rv, 0);        check("rst_b_rv", b_rv, 0);
    check("rst_a_rdata", a_rdata, 0);  check("rst_b_rdata", b_rdata, 0);
    check("rst_a_err", {a_err_addr, a_err_proto}, 0);
    check("rst_b_err", {b_err_addr, b_err_proto}, 0);
    check("rst_a_cnt", {a_wr_cnt, a_rd_cnt}, 0);
    check("rst_b_cnt", {b_wr_cnt, b_rd_cnt}, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) drive(0, 0, 0, 0, 0);
    n_chk++;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d reads still outstanding, required 0/0", qa.size(), qb.size());
    end
  endtask

  always @(posedge bus_clk) cyc <= cyc + 1;

  // Scoreboard: check this cycle's return outputs, then log this cycle's acceptance.
  always @(negedge bus_clk) begin
    if (sb_on) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        check("a_rv_pulse", a_rv, 1);
        check("a_rdata", a_rdata, {24'h0, qa[0].data[7:0]});
        last_a = {24'h0, qa[0].data[7:0]};
        void'(qa.pop_front());
      end else begin
        check("a_rv_idle", a_rv, 0);
        check("a_rdata_hold", a_rdata, last_a);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        check("b_rv_pulse", b_rv, 1);
        check("b_rdata", b_rdata, qb[0].data);
        last_b = qb[0].data;
        void'(qb.pop_front());
      end else begin
        check("b_rv_idle", b_rv, 0);
        check("b_rdata_hold", b_rdata, last_b);
      end

      if (!rstn) begin
        qa.delete(); qb.delete();
        last_a = 0; last_b = 0;
      end else if ((bus_rd || bus_wr) && a_ready) begin
        in_rng = (bus_addr < DEPTH);
        if (bus_rd && !bus_wr) begin
          rd_exp = in_rng ? mdl[bus_addr[9:0]] : 32'hFFFF_FFFF;
          qa.push_back('{due: cyc + 2, data: rd_exp});
          qb.push_back('{due: cyc + 4, data: rd_exp});
        end
        if (bus_wr && in_rng) mdl[bus_addr[9:0]] = wdata32;
      end
    end
  end

  vec_t        vecs[13];
  logic [7:0]  pat;
  logic [15:0] exp_wc, exp_rc;

  initial begin
    //           rd wr clr addr       wdata          wc  rc  ea ep
    vecs[0]  = '{0, 1, 0, 16'd3,    32'h1234_565A, 1,  0,  0, 0};
    vecs[1]  = '{1, 0, 0, 16'd3,    32'h0,         1,  1,  0, 0};
    vecs[2]  = '{0, 1, 0, 16'd1023, 32'hA5B6_C7C3, 2,  1,  0, 0};
    vecs[3]  = '{1, 0, 0, 16'd1023, 32'h0,         2,  2,  0, 0};
    vecs[4]  = '{1, 0, 0, 16'd1024, 32'h0,         2,  3,  1, 0};
    vecs[5]  = '{1, 1, 0, 16'd5,    32'hDEAD_BE77, 3,  3,  1, 1};
    vecs[6]  = '{1, 0, 0, 16'd5,    32'h0,         3,  4,  1, 1};
    vecs[7]  = '{0, 0, 1, 16'd0,    32'h0,         3,  4,  0, 0};
    vecs[8]  = '{0, 1, 1, 16'd2000, 32'h1111_1111, 4,  4,  1, 0};
    vecs[9]  = '{0, 1, 0, 16'd7,    32'h0BAD_F099, 5,  4,  1, 0};
    vecs[10] = '{0, 0, 0, 16'd7,    32'h0,         5,  4,  1, 0};
    vecs[11] = '{1, 0, 0, 16'hFFFF, 32'h0,         5,  5,  1, 0};
    vecs[12] = '{1, 0, 0, 16'd7,    32'h0,         5,  6,  1, 0};

    rstn = 0; bus_rd = 0; bus_wr = 0; err_clr = 0; bus_addr = 0; wdata32 = 0;
    cfg_stall_en = 0; cfg_stall_pat = 8'h00; last_a = 0; last_b = 0;
    repeat (3) @(posedge bus_clk);
    #1;
    sb_on = 1'b1;
    check_reset_vals();
    rstn = 1;
    drive(0, 0, 0, 0, 0);
    check("rel_a_ready", a_ready, 1);
    check("rel_b_ready", b_ready, 1);

    // Directed vectors: function, back-to-back write/read, range and protocol errors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].clr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_a_wr_cnt", i), a_wr_cnt, vecs[i].wc);
      check($sformatf("v%0d_a_rd_cnt", i), a_rd_cnt, vecs[i].rc);
      check($sformatf("v%0d_a_err", i), {a_err_addr, a_err_proto}, {vecs[i].ea, vecs[i].ep});
      check($sformatf("v%0d_b_cnt", i), {b_wr_cnt, b_rd_cnt}, {vecs[i].wc, vecs[i].rc});
      check($sformatf("v%0d_b_err", i), {b_err_addr, b_err_proto}, {vecs[i].ea, vecs[i].ep});
    end
    drive(0, 0, 0, 0, 0);
    drain();
    exp_wc = 16'd5; exp_rc = 16'd6;

    // Preload then stream eight reads back to back.
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 16'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 16'(i), 32'h0);
    drive(0, 0, 0, 0, 0);
    drain();
    exp_wc += 16'd8; exp_rc += 16'd8;
    check("burst_a_cnt", {a_wr_cnt, a_rd_cnt}, {exp_wc, exp_rc});
    check("burst_b_cnt", {b_wr_cnt, b_rd_cnt}, {exp_wc, exp_rc});

    // Throttle: pattern 1010_1010 rotated, writes held for 16 cycles.
    pat = 8'hAA;
    cfg_stall_pat = pat;
    cfg_stall_en  = 1;
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      bus_wr = 1; bus_addr = 16'd10; wdata32 = 32'(k);
      check($sformatf("stall_ready_%0d", k), a_ready, pat[k % 8]);
      @(posedge bus_clk); #1;
    end
    bus_wr = 0;
    exp_wc += 16'd8;
    check("stall_a_wr_cnt", a_wr_cnt, exp_wc);
    check("stall_b_wr_cnt", b_wr_cnt, exp_wc);
    cfg_stall_en = 0;
    drive(0, 0, 0, 0, 0);
    check("unstall_ready", a_ready, 1);
    drive(1, 0, 0, 16'd10, 32'h0);
    drive(0, 0, 0, 0, 0);
    drain();

    // Reset with reads in flight: pending returns must vanish.
    drive(1, 0, 0, 16'd1024, 32'h0);
    drive(1, 0, 0, 16'd3, 32'h0);
    drive(1, 0, 0, 16'd7, 32'h0);
    rstn = 0;
    drive(0, 0, 0, 0, 0);
    check_reset_vals();
    rstn = 1;
    drive(0, 0, 0, 0, 0);
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 1);
    repeat (8) drive(0, 0, 0, 0, 0);
    check("post_rst_cnt", {a_wr_cnt, a_rd_cnt, b_wr_cnt, b_rd_cnt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_mem_serv.md
DMA_MEM_SERV -- requirements
Module: dma_mem_serv

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 8, data width in bits; legal values 8, 16, 32.
- AW, 16, word address width.
- DEPTH, 1024, number of memory words; must be at most 2^AW.
- RD_LAT, 2, read latency in cycles; legal range 1..4.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- bus_clk, in, 1, the only clock.
- rstn, in, 1, reset; synchronous, active-low.
- bus_rd, in, 1, read request.
- bus_wr, in, 1, write request.
- bus_addr, in, AW, word address.
- bus_wdata, in, DW, write data.
- bus_ready, out, 1, slave accepts a request this cycle.
- bus_rdata_ready, out, 1, one-cycle pulse; bus_rdata is valid.
- bus_rdata, out, DW, read data.
- cfg_stall_en, in, 1, enables throttling of bus_ready.
- cfg_stall_pat, in, 8, throttle pattern; a 0 bit means a not-ready cycle.
- err_clr, in, 1, clears both sticky error flags.
- err_addr, out, 1, sticky flag: an access was accepted with an out-of-range address.
- err_proto, out, 1, sticky flag: bus_rd and bus_wr were both high at acceptance.
- wr_cnt, out, 16, count of accepted writes.
- rd_cnt, out, 16, count of accepted reads.

Function
REQ-003 A request SHALL be accepted only in a cycle where (bus_rd or bus_wr) is high and bus_ready is high; all other cycles have no effect on memory or counters.
REQ-004 bus_ready SHALL be a register output that never depends combinationally on the request inputs.
REQ-005 When cfg_stall_en is 0, bus_ready SHALL be 1 in every cycle after reset.
REQ-006 When cfg_stall_en is 1, an 8-bit rotate register SHALL load cfg_stall_pat on the enable rising edge, then rotate right by 1 each cycle; bus_ready SHALL equal bit 0 of the rotate register.
REQ-007 Writes SHALL be accepted at one per cycle; an accepted write with bus_addr < DEPTH SHALL update mem[bus_addr] at the end of the acceptance cycle.
REQ-008 Reads SHALL be fully pipelined at one per cycle: a read accepted in cycle T SHALL produce a bus_rdata_ready pulse in cycle T+RD_LAT, with bus_rdata = mem[addr] sampled in cycle T.
REQ-009 bus_rdata SHALL hold its last value whenever bus_rdata_ready is 0.
REQ-010 A read accepted in cycle T+1 to the address written in cycle T SHALL return the new data.
REQ-011 An out-of-range access (bus_addr >= DEPTH) SHALL set err_addr; the write is dropped, and the read still pulses bus_rdata_ready with data all ones.
REQ-012 If bus_rd and bus_wr are both high at acceptance, the write SHALL be performed, the read SHALL be dropped (no rdata pulse), err_proto SHALL be set, and only wr_cnt SHALL increment.
REQ-013 When err_clr and a new error occur in the same cycle, the set SHALL win.
REQ-014 wr_cnt and rd_cnt SHALL count accepted requests, including out-of-range ones, and SHALL saturate at 0xFFFF.
REQ-015 Memory contents SHALL NOT be reset.

Reset
REQ-016 While rstn is 0, on each clock edge: bus_ready=0, bus_rdata_ready=0, bus_rdata=0, err_addr=0, err_proto=0, wr_cnt=0, rd_cnt=0, and the rotate register is loaded with 8'hFF.
REQ-017 Reads pending in the pipeline at reset assertion SHALL be discarded; no bus_rdata_ready pulse SHALL appear after reset for a read accepted before reset.
REQ-018 bus_ready SHALL rise in the first cycle after rstn is sampled high (with cfg_stall_en=0).

Structure
REQ-019 Package dma_mem_pkg SHALL hold the default values for DW, AW, DEPTH and RD_LAT, the maximum RD_LAT (4), the counter width (16) and the stall pattern width (8).
REQ-020 The read pipeline SHALL be a single sub-module dma_rd_pipe: an RD_LAT-deep valid/data shift chain with synchronous clear.

Verification
REQ-021 Default parameters, cfg_stall_en=0:
- Write 0x5A to address 3, then read address 3 on the next cycle.
- Required: bus_rdata_ready pulses exactly 2 cycles after the read is accepted, with bus_rdata=0x5A; wr_cnt=1, rd_cnt=1.
REQ-022 RD_LAT=4, DW=32:
- Issue back-to-back reads of addresses 0..7 after preloading data = addr*0x01010101.
- Required: 8 consecutive bus_rdata_ready pulses, the first 4 cycles after the first acceptance, with data in order.
REQ-023 cfg_stall_en=1, cfg_stall_pat=8'b1010_1010, bus_wr held high for 16 cycles:
- Required: bus_ready alternates 0/1 in the rotated pattern, and wr_cnt=8 after 16 cycles.
REQ-024 Error cases, DEPTH=1024:
- Read address 1024. Required: rdata = all ones and err_addr=1.
- Then assert bus_rd and bus_wr together. Required: err_proto=1, no rdata pulse, wr_cnt increments.
- Then assert err_clr alone. Required: both flags clear.
REQ-025 Reset mid-operation:
- Accept 2 reads, then assert rstn=0 for 1 cycle.
- Required: no bus_rdata_ready pulse afterwards; all outputs equal their reset values; bus_ready=1 one cycle after release.
